// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: one memory port shared by fetch and data.
// Data wins ties; STALL holds the pipeline until both accesses finish.
module pipeline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREAD,
  input  logic [ADDR_W-1:0] IADDR,
  output logic [DATA_W-1:0] IREADDATA,
  output logic              IBUSYWAIT,
  input  logic              DREAD,
  input  logic              DWRITE,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic [DATA_W-1:0] DWRITEDATA,
  output logic [DATA_W-1:0] DREADDATA,
  output logic              DBUSYWAIT,
  output logic              STALL,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_D,
    SERVE_I
  } state_t;

  state_t state, state_n;
  logic   done_i, done_d, first;
  logic   dreq, pend_i, pend_d;
  logic   comp, grant_i, grant_d;
  logic   comp_i, comp_d;

  assign dreq      = DREAD | DWRITE;
  assign pend_d    = dreq & ~done_d;
  assign pend_i    = IREAD & ~done_i;
  assign DBUSYWAIT = pend_d;
  assign IBUSYWAIT = pend_i;
  assign STALL     = pend_d | pend_i;

  // The first serve cycle never completes, whatever the memory says.
  assign comp   = (state != IDLE) & ~first & ~MEM_BUSYWAIT;
  assign comp_d = comp & (state == SERVE_D);
  assign comp_i = comp & (state == SERVE_I);

  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_d)      grant_d = 1'b1;
        else if (pend_i) grant_i = 1'b1;
      end
      SERVE_D: begin
        if (comp) begin
          if (pend_i) grant_i = 1'b1;
          else        state_n = IDLE;
        end
      end
      SERVE_I: begin
        if (comp) begin
          if (pend_d) grant_d = 1'b1;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (grant_d) state_n = SERVE_D;
    if (grant_i) state_n = SERVE_I;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      first         <= 1'b0;
      done_i        <= 1'b0;
      done_d        <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      IREADDATA     <= '0;
      DREADDATA     <= '0;
    end else begin
      state  <= state_n;
      first  <= grant_d | grant_i;
      // Done sticks until the pipeline advances or the request goes away.
      done_d <= (done_d | comp_d) & STALL & dreq;
      done_i <= (done_i | comp_i) & STALL & IREAD;
      if (comp) begin
        MEM_READ  <= 1'b0;
        MEM_WRITE <= 1'b0;
      end
      if (comp_d && MEM_READ) DREADDATA <= MEM_READDATA;
      if (comp_i)             IREADDATA <= MEM_READDATA;
      if (grant_d) begin
        MEM_READ      <= DREAD & ~DWRITE;
        MEM_WRITE     <= DWRITE;
        MEM_ADDRESS   <= DADDR;
        MEM_WRITEDATA <= DWRITEDATA;
      end
      if (grant_i) begin
        MEM_READ    <= 1'b1;
        MEM_WRITE   <= 1'b0;
        MEM_ADDRESS <= IADDR;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter: directed and random checks of the arbiter
// against a behavioural memory with programmable wait cycles.
module tb_pipeline_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iread = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] ireaddata;
  logic        ibusywait;
  logic        dread = 1'b0;
  logic        dwrite = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwritedata = '0;
  logic [31:0] dreaddata;
  logic        dbusywait;
  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int errors = 0;
  int checks = 0;

  pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(clk), .RESET(reset),
    .IREAD(iread), .IADDR(iaddr), .IREADDATA(ireaddata), .IBUSYWAIT(ibusywait),
    .DREAD(dread), .DWRITE(dwrite), .DADDR(daddr), .DWRITEDATA(dwritedata),
    .DREADDATA(dreaddata), .DBUSYWAIT(dbusywait), .STALL(stall),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata),
    .MEM_BUSYWAIT(mem_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    case (i)
      16:      return 32'h0050_0093;
      17:      return 32'h00A0_0113;
      64:      return 32'hDEAD_BEEF;
      65:      return 32'hCAFE_F00D;
      192:     return 32'h0BAD_F00D;
      default: return 32'hA500_0000 | i;
    endcase
  endfunction

  // Memory model: busy for waits+1 cycles of each access, first included.
  logic [31:0] mem [256];
  logic [255:0] wflag = '0;
  int waits = 0;
  int cnt = 0;
  int icnt = 0;
  int dcnt = 0;
  logic [7:0] midx;
  logic [31:0] shadow [256];

  assign midx = mem_address[9:2];
  assign mem_busywait = (mem_read | mem_write) && (cnt < waits + 1);
  assign mem_readdata = wflag[midx] ? mem[midx] : init_val(int'(midx));

  always @(posedge clk) begin
    if (mem_read | mem_write) begin
      if (mem_busywait) cnt <= cnt + 1;
      else begin
        cnt <= 0;
        if (mem_write) begin
          mem[midx]   <= mem_writedata;
          wflag[midx] <= 1'b1;
        end
        if (mem_address < 32'h100) icnt <= icnt + 1;
        else                       dcnt <= dcnt + 1;
      end
    end else cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b000) begin
      errors++;
      $display("FAIL rst_strobes got=%b want=000", {mem_read, mem_write, stall});
    end
    checks++;
    if ({mem_address, mem_writedata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mem_bus got=%h want=0", {mem_address, mem_writedata});
    end
    checks++;
    if ({ireaddata, dreaddata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_rdata got=%h want=0", {ireaddata, dreaddata});
    end
    iread = 1'b1;
    #1;
    checks++;
    if ({ibusywait, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_busy_follows got=%b want=11", {ibusywait, stall});
    end
    iread = 1'b0;
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    waits = 0;
    tick();
    iread = 1'b1;
    iaddr = 32'h40;
    #1;
    checks++;
    if ({ibusywait, dbusywait, stall, mem_read} !== 4'b1010) begin
      errors++;
      $display("FAIL fetch_c0 got=%b want=1010",
               {ibusywait, dbusywait, stall, mem_read});
    end
    tick();
    checks++;
    if ({mem_read, mem_write, ibusywait} !== 3'b101 || mem_address !== 32'h40) begin
      errors++;
      $display("FAIL fetch_c1 got=%b/%h want=101/40",
               {mem_read, mem_write, ibusywait}, mem_address);
    end
    tick();
    checks++;
    if ({mem_read, ibusywait} !== 2'b11) begin
      errors++;
      $display("FAIL fetch_c2 got=%b want=11", {mem_read, ibusywait});
    end
    tick();
    checks++;
    if ({mem_read, ibusywait, stall} !== 3'b000 || ireaddata !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch_c3 got=%b/%h want=000/00500093",
               {mem_read, ibusywait, stall}, ireaddata);
    end
    iread = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int i0, d0;
    waits = 0;
    tick();
    i0 = icnt;
    d0 = dcnt;
    dread = 1'b1;
    daddr = 32'h100;
    iread = 1'b1;
    iaddr = 32'h44;
    #1;
    checks++;
    if ({dbusywait, ibusywait, stall} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_c0 got=%b want=111", {dbusywait, ibusywait, stall});
    end
    tick();
    checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_address !== 32'h100) begin
      errors++;
      $display("FAIL b2b_c1 got=%b/%h want=10/100", {mem_read, mem_write}, mem_address);
    end
    tick();
    tick();
    checks++;
    if ({mem_read, dbusywait, ibusywait, stall} !== 4'b1011 || mem_address !== 32'h44) begin
      errors++;
      $display("FAIL b2b_c3 got=%b/%h want=1011/44",
               {mem_read, dbusywait, ibusywait, stall}, mem_address);
    end
    checks++;
    if (dreaddata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL b2b_dread got=%h want=deadbeef", dreaddata);
    end
    tick();
    checks++;
    if (stall !== 1'b1 || dreaddata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL b2b_c4 got=%b/%h want=1/deadbeef", stall, dreaddata);
    end
    tick();
    checks++;
    if ({stall, ibusywait, dbusywait, mem_read} !== 4'b0000
        || ireaddata !== 32'h00A0_0113) begin
      errors++;
      $display("FAIL b2b_c5 got=%b/%h want=0000/00a00113",
               {stall, ibusywait, dbusywait, mem_read}, ireaddata);
    end
    checks++;
    if (icnt - i0 != 1 || dcnt - d0 != 1) begin
      errors++;
      $display("FAIL b2b_counts got=%0d/%0d want=1/1", icnt - i0, dcnt - d0);
    end
    dread = 1'b0;
    iread = 1'b0;
    tick();
  endtask

  task automatic test_no_reservice();
    int d0, cyc, dlow;
    waits = 3;
    tick();
    d0 = dcnt;
    dlow = -1;
    dread = 1'b1;
    daddr = 32'h104;
    iread = 1'b1;
    iaddr = 32'h48;
    #1;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (!stall) break;
      tick();
      if (!dbusywait && dlow < 0) dlow = cyc + 1;
      if (!dbusywait && stall) begin
        checks++;
        if (dreaddata !== 32'hCAFE_F00D) begin
          errors++;
          $display("FAIL norsv_hold cyc=%0d got=%h want=cafef00d", cyc + 1, dreaddata);
        end
      end
    end
    checks++;
    if (cyc != 11 || dlow != 6) begin
      errors++;
      $display("FAIL norsv_timing got=%0d/%0d want=11/6", cyc, dlow);
    end
    checks++;
    if (dcnt - d0 != 1 || ireaddata !== 32'hA500_0012) begin
      errors++;
      $display("FAIL norsv_once got=%0d/%h want=1/a5000012", dcnt - d0, ireaddata);
    end
    dread = 1'b0;
    iread = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int cyc, wr;
    waits = 2;
    wr = 0;
    tick();
    dwrite = 1'b1;
    daddr = 32'h200;
    dwritedata = 32'h1234_5678;
    #1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (!dbusywait) break;
      tick();
      if (mem_write) begin
        wr++;
        checks++;
        if (mem_writedata !== 32'h1234_5678 || mem_read !== 1'b0) begin
          errors++;
          $display("FAIL store_bus got=%h/%b want=12345678/0", mem_writedata, mem_read);
        end
      end
    end
    checks++;
    if (cyc != 5 || wr != 4) begin
      errors++;
      $display("FAIL store_timing got=%0d/%0d want=5/4", cyc, wr);
    end
    checks++;
    if (dreaddata !== 32'hCAFE_F00D || mem[128] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_data got=%h/%h want=cafef00d/12345678", dreaddata, mem[128]);
    end
    shadow[128] = 32'h1234_5678;
    dwrite = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    waits = 3;
    tick();
    dread = 1'b1;
    daddr = 32'h300;
    tick();
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got=%b want=1", mem_read);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_read, mem_write, dbusywait} !== 3'b001 || mem_address !== 32'h0) begin
      errors++;
      $display("FAIL rmid_strobes got=%b/%h want=001/0",
               {mem_read, mem_write, dbusywait}, mem_address);
    end
    checks++;
    if ({ireaddata, dreaddata} !== 64'h0) begin
      errors++;
      $display("FAIL rmid_rdata got=%h want=0", {ireaddata, dreaddata});
    end
    waits = 0;
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if ({mem_read, dbusywait} !== 2'b11 || mem_address !== 32'h300) begin
      errors++;
      $display("FAIL rmid_regrant got=%b/%h want=11/300", {mem_read, dbusywait}, mem_address);
    end
    tick();
    tick();
    checks++;
    if ({mem_read, dbusywait} !== 2'b00 || dreaddata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL rmid_done got=%b/%h want=00/0badf00d", {mem_read, dbusywait}, dreaddata);
    end
    dread = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int kind, ireq, ia, da, cyc, i0, d0;
    logic [31:0] wd, exp_d;
    exp_d = 32'h0BAD_F00D;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      ireq = $urandom_range(0, 1);
      ia = $urandom_range(0, 63);
      da = $urandom_range(64, 127);
      wd = $urandom;
      waits = $urandom_range(0, 3);
      i0 = icnt;
      d0 = dcnt;
      iread = (ireq == 1);
      iaddr = 32'(ia * 4);
      dread = (kind == 1 || kind == 3);
      dwrite = (kind >= 2);
      daddr = 32'(da * 4);
      dwritedata = wd;
      #1;
      for (cyc = 0; cyc < 100; cyc++) begin
        checks++;
        if (mem_read && mem_write) begin
          errors++;
          $display("FAIL rnd_excl slot=%0d got=11 want=not both", s);
        end
        if (!stall) break;
        tick();
      end
      if (cyc == 100) begin
        errors++;
        $display("FAIL rnd_timeout slot=%0d stall=%b want=0", s, stall);
      end
      checks++;
      if (icnt - i0 != ireq || dcnt - d0 != int'(kind != 0)) begin
        errors++;
        $display("FAIL rnd_once slot=%0d got=%0d/%0d want=%0d/%0d",
                 s, icnt - i0, dcnt - d0, ireq, int'(kind != 0));
      end
      if (ireq == 1) begin
        checks++;
        if (ireaddata !== shadow[ia]) begin
          errors++;
          $display("FAIL rnd_iread slot=%0d got=%h want=%h", s, ireaddata, shadow[ia]);
        end
      end
      if (kind == 1) exp_d = shadow[da];
      checks++;
      if (dreaddata !== exp_d) begin
        errors++;
        $display("FAIL rnd_dread slot=%0d got=%h want=%h", s, dreaddata, exp_d);
      end
      if (kind >= 2) begin
        shadow[da] = wd;
        checks++;
        if (mem[da] !== wd) begin
          errors++;
          $display("FAIL rnd_store slot=%0d got=%h want=%h", s, mem[da], wd);
        end
      end
      iread = 1'b0;
      dread = 1'b0;
      dwrite = 1'b0;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    test_reset();
    test_fetch();
    test_back_to_back();
    test_no_reservice();
    test_store();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
# pipeline_mem_arbiter

Shares one main-memory port between the instruction-fetch port (read-only) and the data port (read/write) of the 5-stage pipeline. It generates a busywait for each port and a global STALL. STALL drives the BUSYWAIT input of every pipeline register, so the whole pipeline freezes until both of the current cycle's memory accesses have completed. Read data is registered and held stable while the pipeline is stalled.

## Interface
- ADDR_W, 32, address width for both ports and the memory
- DATA_W, 32, data width
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high
- IREAD  in  1  instruction fetch request (level)
- IADDR  in  ADDR_W  fetch address
- IREADDATA  out  DATA_W  fetched word (registered)
- IBUSYWAIT  out  1  fetch port not yet serviced
- DREAD  in  1  data load request (level)
- DWRITE  in  1  data store request (level)
- DADDR  in  ADDR_W  data address
- DWRITEDATA  in  DATA_W  store data
- DREADDATA  out  DATA_W  loaded word (registered)
- DBUSYWAIT  out  1  data port not yet serviced
- STALL  out  1  IBUSYWAIT | DBUSYWAIT, fed to pipeline-register BUSYWAIT
- MEM_READ  out  1  memory read strobe (registered)
- MEM_WRITE  out  1  memory write strobe (registered)
- MEM_ADDRESS  out  ADDR_W  memory address (registered)
- MEM_WRITEDATA  out  DATA_W  memory write data (registered)
- MEM_READDATA  in  DATA_W  memory read data, valid when MEM_BUSYWAIT low
- MEM_BUSYWAIT  in  1  memory busy

## Operation
**State machine:** IDLE, SERVE_D, SERVE_I.

**Pending flags**
- pend_d = (DREAD|DWRITE) & !done_d
- pend_i = IREAD & !done_i

**Busywait outputs** (combinational)
- DBUSYWAIT = pend_d; IBUSYWAIT = pend_i; STALL = DBUSYWAIT | IBUSYWAIT.

**IDLE**
- If pend_d, go to SERVE_D. Else if pend_i, go to SERVE_I.
- Data has fixed priority because it belongs to the older instruction.
- On the transition edge, load MEM_ADDRESS, MEM_WRITEDATA and MEM_READ/MEM_WRITE from the winning port.
- DWRITE with DREAD both set is illegal; DWRITE wins.

**SERVE_x**
- MEM_BUSYWAIT is ignored in the first SERVE cycle; a `first` bit tracks this.
- From the second cycle on, the first edge with MEM_BUSYWAIT=0 is the completion edge. On that edge:
  - reads: capture MEM_READDATA into xREADDATA;
  - set done_x;
  - drop MEM_READ and MEM_WRITE.
- Next state after completion:
  - if the other port is pending, go directly to its SERVE state, loading its strobes on the same edge;
  - otherwise go to IDLE.
- Stores leave DREADDATA unchanged.

**Done flags**
- done_x is cleared on any edge where STALL=0 (the pipeline advances) or the port's request is low.
- This prevents a stalled, already-serviced request from being serviced again.

**Output hold**
- IREADDATA and DREADDATA change only on their own port's completion edge.

**Port address/data stability**
- IADDR, DADDR and DWRITEDATA must stay stable while the port is pending.
- They are sampled only on the grant edge; later changes do not affect an access in flight.

**Reset**
- RESET asserted at any time, including mid-access, forces all of the following immediately:
  - state=IDLE;
  - MEM_READ=0, MEM_WRITE=0;
  - MEM_ADDRESS=0, MEM_WRITEDATA=0;
  - IREADDATA=0, DREADDATA=0;
  - done_i=0, done_d=0, first=0.
- After release, IBUSYWAIT and DBUSYWAIT follow the request inputs combinationally.

## Timing
- Busywait rises in the same cycle a request appears; there is no registered delay.
- Single port, memory with 0 wait states:
  - request in cycle 0 (IDLE);
  - MEM_READ high in cycles 1 and 2;
  - completion edge at the end of cycle 2;
  - busywait low and data valid from cycle 3.
- Memory with N wait cycles after the first SERVE cycle: completion moves N cycles later.
- Both ports in cycle 0 with 0-wait memory:
  - SERVE_D in cycles 1-2;
  - SERVE_I in cycles 3-4;
  - DBUSYWAIT low from cycle 3, IBUSYWAIT low from cycle 5;
  - STALL low from cycle 5;
  - both done flags cleared at the end of cycle 5.
- At most one memory access is outstanding at any time.
- MEM_READ and MEM_WRITE are never both high.

## Test plan
- **Fetch only, 0-wait memory:** IREAD=1, IADDR=0x40, memory returns 0x00500093 → MEM_READ high in cycles 1-2; IBUSYWAIT low and IREADDATA=0x00500093 from cycle 3.
- **Simultaneous load and fetch:** DREAD at DADDR=0x100 (mem 0xDEADBEEF), IREAD at IADDR=0x44 → data is serviced first, then the fetch back-to-back with no IDLE cycle; DREADDATA=0xDEADBEEF from cycle 3; STALL low at cycle 5.
- **Store with 2 wait cycles:** DWRITE, DADDR=0x200, DWRITEDATA=0x12345678 → MEM_WRITE high 4 cycles with MEM_WRITEDATA=0x12345678; DREADDATA unchanged; DBUSYWAIT low from cycle 5.
- **No re-service while stalled:** load completes while the fetch is still pending, DREAD held high → no second MEM_READ to the data address; DREADDATA stays stable until STALL drops.
- **Reset mid-access:** RESET pulsed in the second SERVE_D cycle → MEM_READ=0 and both read-data outputs 0 immediately; after release the held request restarts from IDLE.
- **Memory-port exclusivity:** random request streams, random memory waits → MEM_READ & MEM_WRITE never both high; every request is serviced exactly once per STALL-low edge.
